fifo_sync_lvl: RTL
==================

// Module: fifo_sync_lvl
// PURPOSE
// - Single-clock parametrised FIFO: next-generation buffer for the digital interface datapath.
// - Adds over the previous FIFO:
//   - occupancy count
//   - programmable almost-full / almost-empty thresholds
//   - sticky overflow / underflow error flags
//   - optional first-word-fall-through (FWFT) read mode
// - Sits between the sample producer and the serial/host interface; both run on one clock.
// PARAMETERS
// - DATA_WIDTH  16  word width in bits
// - DATA_ADDR   8   address width; depth = 2**DATA_ADDR
// - AF_THRESH   240 ALMOST_FULL asserts when LEVEL >= AF_THRESH (1..2**DATA_ADDR)
// - AE_THRESH   16  ALMOST_EMPTY asserts when LEVEL <= AE_THRESH (0..2**DATA_ADDR-1)
// PORTS
// - CLK           in   1            single clock, rising edge
// - RST           in   1            synchronous reset, active-high
// - WR_EN         in   1            write request
// - WR_DATA       in   DATA_WIDTH   write word
// - RD_EN         in   1            read request (FWFT: acknowledge of head word)
// - CLR_ERR       in   1            clears OVERFLOW/UNDERFLOW
// - RD_DATA       out  DATA_WIDTH   read word
// - RD_VALID      out  1            RD_DATA holds a valid word
// - EMPTY, FULL   out  1            occupancy flags
// - ALMOST_EMPTY  out  1            LEVEL <= AE_THRESH
// - ALMOST_FULL   out  1            LEVEL >= AF_THRESH
// - LEVEL         out  DATA_ADDR+1  words stored, 0..2**DATA_ADDR
// - OVERFLOW      out  1            sticky: write attempted while FULL
// - UNDERFLOW     out  1            sticky: read attempted while EMPTY
// BEHAVIOUR
// - Reset state (RST=1 at a CLK edge):
//   - pointers, LEVEL, RD_DATA = 0; RD_VALID = 0; EMPTY = 1; FULL = 0
//   - ALMOST_EMPTY = 1; ALMOST_FULL = 0; OVERFLOW = UNDERFLOW = 0
//   - Storage is not cleared.
//   - Reset mid-operation discards all contents; RST wins over every other input.
// - Pointers: WR_PTR/RD_PTR are DATA_ADDR+1 bits; MSB is the wrap bit; low bits index storage.
//   - EMPTY = (WR_PTR == RD_PTR)
//   - FULL  = (MSBs differ) && (low bits equal)
//   - LEVEL = WR_PTR - RD_PTR, modulo 2**(DATA_ADDR+1)
//   - All flags decode from registered pointers and update the cycle after an accepted operation.
// - Write accepted iff WR_EN && !FULL; read accepted iff RD_EN && !EMPTY.
//   - Flags are sampled before the edge: a write while FULL is rejected even if a read is accepted in the same cycle.
//   - Likewise, a read while EMPTY is rejected even if a write is accepted in the same cycle.
// - Simultaneous accepted read+write: both pointers advance; LEVEL unchanged.
// - Errors: WR_EN && FULL sets OVERFLOW; RD_EN && EMPTY sets UNDERFLOW.
//   - CLR_ERR clears both; a new error event in the same cycle as CLR_ERR wins (flag stays 1).
// - Standard read mode:
//   - Read latency is 1 cycle: RD_DATA is registered and RD_VALID pulses for 1 cycle after an accepted read.
//   - RD_DATA holds its last value otherwise.
// CONFIGURATION
// - Macro FIFO_SYNC_FWFT_EN.
//   - Defined: head word is presented on RD_DATA while !EMPTY; RD_VALID = !EMPTY.
//     RD_EN pops the head, and the next word (if any) appears the following cycle.
//     Same LEVEL/flag semantics; read latency 0.
//   - Undefined: standard 1-cycle read mode as above.
// STRUCTURE
// - Package fifo_sync_pkg:
//   - ptr width function clog2
//   - threshold range-check constants
//   - default parameter values
// - Sub-module fifo_sync_ram: DATA_WIDTH x 2**DATA_ADDR storage.
//   - One write port, one read port (registered or async read, selected by the macro).
// - fifo_sync_lvl holds the pointers, flags, level and error logic.
// TESTING (DATA_WIDTH=16, DATA_ADDR=3, AF_THRESH=6, AE_THRESH=1)
// - Write 8'h words 0x0001..0x0008 -> FULL=1 after 8th, LEVEL=8, ALMOST_FULL=1 from LEVEL=6;
//   9th write (0x0009) -> OVERFLOW=1, storage unchanged.
// - Read 8 words -> RD_DATA 0x0001..0x0008 in order, RD_VALID one cycle after each RD_EN;
//   then EMPTY=1, extra read -> UNDERFLOW=1.
// - At LEVEL=4, WR_EN+RD_EN together for 10 cycles -> LEVEL stays 4; pointers wrap; data order preserved.
// - FULL with WR_EN+RD_EN -> read accepted, write rejected, OVERFLOW=1, LEVEL=7.
// - RST pulse at LEVEL=5 -> next cycle EMPTY=1, LEVEL=0, RD_VALID=0; CLR_ERR clears sticky flags.
// - With FIFO_SYNC_FWFT_EN: write 0x00A5 into empty FIFO -> RD_DATA=0x00A5, RD_VALID=1 without RD_EN;
//   RD_EN -> EMPTY=1 next cycle.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// ----------------------------------------------------------------------------
// fifo_sync_pkg
// Shared definitions for the single-clock level-reporting FIFO.
//   - default parameter values for fifo_sync_lvl
//   - threshold range limits (almost-full / almost-empty)
//   - clog2 helper used to size the wrap-bit pointers
// No ports (package).
// ----------------------------------------------------------------------------
package fifo_sync_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int DATA_ADDR_DEF  = 8;
    localparam int AF_THRESH_DEF  = 240;
    localparam int AE_THRESH_DEF  = 16;

    // Legal threshold ranges: AF in 1..DEPTH, AE in 0..DEPTH-1.
    localparam int AF_THRESH_MIN  = 1;
    localparam int AE_THRESH_MIN  = 0;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            res = res + 1;
        end
        return res;
    endfunction

    function automatic int af_thresh_max(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int ae_thresh_max(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

// File: rtl/fifo_sync_lvl_if.sv
// ----------------------------------------------------------------------------
// fifo_sync_lvl_if
// Handshake/status bundle between the FIFO and its producer/consumer.
//   master : drives WR_EN, WR_DATA, RD_EN, CLR_ERR; observes read data/status
//   slave  : the FIFO side (mirror of master)
// Status: RD_DATA, RD_VALID, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
//         LEVEL (DATA_ADDR+1 bits), OVERFLOW, UNDERFLOW.
// ----------------------------------------------------------------------------
interface fifo_sync_lvl_if
    import fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DATA_ADDR  = DATA_ADDR_DEF
);
    logic                  WR_EN;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  RD_EN;
    logic                  CLR_ERR;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  RD_VALID;
    logic                  EMPTY;
    logic                  FULL;
    logic                  ALMOST_EMPTY;
    logic                  ALMOST_FULL;
    logic [DATA_ADDR:0]    LEVEL;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;

    modport master (
        output WR_EN, WR_DATA, RD_EN, CLR_ERR,
        input  RD_DATA, RD_VALID, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
               LEVEL, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  WR_EN, WR_DATA, RD_EN, CLR_ERR,
        output RD_DATA, RD_VALID, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
               LEVEL, OVERFLOW, UNDERFLOW
    );

endinterface

// File: rtl/fifo_sync_ram.sv
// ----------------------------------------------------------------------------
// fifo_sync_ram
// DATA_WIDTH x 2**DATA_ADDR storage, one write port and one read port.
// Configuration macro: FIFO_SYNC_FWFT_EN
//   defined   : asynchronous read (head word visible immediately)
//   undefined : registered read, output register cleared by RST
// Ports: CLK, RST, wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_data.
// Storage itself is never reset.
// ----------------------------------------------------------------------------
module fifo_sync_ram
    import fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DATA_ADDR  = DATA_ADDR_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_en,
    input  logic [DATA_ADDR-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [DATA_ADDR-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [1 << DATA_ADDR];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    // Read side is combinational; reset and read strobe are not needed here.
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = &{1'b0, RST, rd_en};
    assign rd_data = mem[rd_addr];
`else
    logic [DATA_WIDTH-1:0] rd_data_p1;

    // Stage p1: registered read word, holds until the next accepted read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data_p1 <= '0;
        end else if (rd_en) begin
            rd_data_p1 <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_p1;
`endif

endmodule

// File: rtl/fifo_sync_lvl.sv
// ----------------------------------------------------------------------------
// fifo_sync_lvl
// Single-clock FIFO with occupancy level, almost-full/almost-empty thresholds
// and sticky overflow/underflow flags.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous reset, active-high (wins over every other input)
//   bus  - fifo_sync_lvl_if.slave (write/read requests, CLR_ERR, read data
//          and all status outputs)
// Configuration macro: FIFO_SYNC_FWFT_EN
//   defined   : first-word-fall-through, RD_VALID = !EMPTY, RD_EN pops head
//   undefined : standard mode, RD_DATA/RD_VALID one cycle after accepted read
// ----------------------------------------------------------------------------
module fifo_sync_lvl
    import fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DATA_ADDR  = DATA_ADDR_DEF,
    parameter int AF_THRESH  = AF_THRESH_DEF,
    parameter int AE_THRESH  = AE_THRESH_DEF
) (
    input logic             CLK,
    input logic             RST,
    fifo_sync_lvl_if.slave  bus
);

    localparam int DEPTH = 1 << DATA_ADDR;
    // One extra pointer bit distinguishes full from empty.
    localparam int PTR_W = clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);

    if (AF_THRESH < AF_THRESH_MIN || AF_THRESH > af_thresh_max(DATA_ADDR)) begin : g_af_range
        $error("fifo_sync_lvl: AF_THRESH out of range");
    end
    if (AE_THRESH < AE_THRESH_MIN || AE_THRESH > ae_thresh_max(DATA_ADDR)) begin : g_ae_range
        $error("fifo_sync_lvl: AE_THRESH out of range");
    end

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      level;
    logic                  empty;
    logic                  full;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf;
    logic                  unf;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    assign level  = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                    (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
    // Acceptance uses pre-edge flags, so a read cannot make room for a
    // same-cycle write when full (and vice versa when empty).
    assign wr_acc = bus.WR_EN && !full;
    assign rd_acc = bus.RD_EN && !empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A fresh error event outranks a same-cycle clear.
            if (bus.WR_EN && full) begin
                ovf <= 1'b1;
            end else if (bus.CLR_ERR) begin
                ovf <= 1'b0;
            end
            if (bus.RD_EN && empty) begin
                unf <= 1'b1;
            end else if (bus.CLR_ERR) begin
                unf <= 1'b0;
            end
        end
    end

    fifo_sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_ADDR  (DATA_ADDR)
    ) u_ram (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[DATA_ADDR-1:0]),
        .wr_data (bus.WR_DATA),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr[DATA_ADDR-1:0]),
        .rd_data (ram_rd_data)
    );

`ifdef FIFO_SYNC_FWFT_EN
    // Uninitialised storage is masked while empty so RD_DATA reads 0 then.
    assign bus.RD_DATA  = empty ? '0 : ram_rd_data;
    assign bus.RD_VALID = !empty;
`else
    logic rd_vld_p1;

    // Stage p1: valid pulse aligned with the registered read word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= rd_acc;
        end
    end

    assign bus.RD_DATA  = ram_rd_data;
    assign bus.RD_VALID = rd_vld_p1;
`endif

    assign bus.EMPTY        = empty;
    assign bus.FULL         = full;
    assign bus.LEVEL        = level;
    assign bus.ALMOST_FULL  = (level >= AF_LVL);
    assign bus.ALMOST_EMPTY = (level <= AE_LVL);
    assign bus.OVERFLOW     = ovf;
    assign bus.UNDERFLOW    = unf;

endmodule
